// File: rtl/fb_fill_pkg.sv
// fb_fill_pkg: register map, CTRL/STATUS bit positions and FSM state type for fb_fill_engine
package fb_fill_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_BASE   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_COLOUR = 2'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;

    typedef enum logic {IDLE, RUN} state_e;

endpackage

// File: rtl/fb_fill_if.sv
// fb_fill_if: control slave bus plus SDRAM write master bus of the fill engine
interface fb_fill_if;

    logic [1:0]  slave_address;
    logic        slave_read_en;
    logic        slave_write_en;
    logic [31:0] slave_read_data;
    logic [31:0] slave_write_data;
    logic [31:0] master_address;
    logic        master_write;
    logic [31:0] master_write_data;
    logic        master_wait_request;

    // engine side: serves register accesses and drives SDRAM writes
    modport master (
        input  slave_address, slave_read_en, slave_write_en, slave_write_data, master_wait_request,
        output slave_read_data, master_address, master_write, master_write_data
    );

    // environment side: CPU issuing register accesses and the SDRAM fabric accepting writes
    modport slave (
        output slave_address, slave_read_en, slave_write_en, slave_write_data, master_wait_request,
        input  slave_read_data, master_address, master_write, master_write_data
    );

endinterface

// File: rtl/fb_fill_addr_gen.sv
// fb_fill_addr_gen: working write pointer and remaining-word counter of a fill
module fb_fill_addr_gen (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load_i,
    input  logic        advance_i,
    input  logic [31:0] base_i,
    input  logic [31:0] count_i,
    output logic [31:0] ptr_o,
    output logic        last_o
);

    logic [31:0] ptr_q;
    logic [31:0] remaining_q;

    // load a new fill, or step one word per accepted beat (pointer wraps at 32 bits)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q       <= '0;
            remaining_q <= '0;
        end else if (load_i) begin
            ptr_q       <= base_i;
            remaining_q <= count_i;
        end else if (advance_i) begin
            ptr_q       <= ptr_q + 32'd4;
            remaining_q <= remaining_q - 32'd1;
        end
    end

    assign ptr_o  = ptr_q;
    assign last_o = remaining_q == 32'd1;

endmodule

// File: rtl/fb_fill_engine.sv
// fb_fill_engine: Avalon-MM DMA that fills a linear SDRAM region with a constant word
// Optional feature: define FB_FILL_IRQ_EN to add the irq port and the CTRL bit2 irq enable.
module fb_fill_engine
    import fb_fill_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    fb_fill_if.master bus
`ifdef FB_FILL_IRQ_EN
    ,
    output logic irq
`endif
);

    state_e      state_q;
    logic        master_write_q;
    logic [31:0] colour_w_q;
    logic        abort_pend_q;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;
    logic [31:0] base_q, count_q, colour_q;
    logic [31:0] ptr;
    logic        last;
    logic        wr_ctrl, start, abort_wr, rd_status, accept, finish, aborting, load, zero_start;
    logic [31:0] rdata;

    assign wr_ctrl    = bus.slave_write_en && bus.slave_address == REG_CTRL;
    assign start      = wr_ctrl && bus.slave_write_data[CTRL_START];
    assign abort_wr   = wr_ctrl && bus.slave_write_data[CTRL_ABORT];
    assign rd_status  = bus.slave_read_en && bus.slave_address == REG_CTRL;
    assign accept     = master_write_q && !bus.master_wait_request;
    // an abort written in the same cycle as an accepted beat ends the fill on that beat
    assign aborting   = abort_pend_q || abort_wr;
    assign finish     = state_q == RUN && accept && (last || aborting);
    assign load       = state_q == IDLE && start && count_q != 32'd0;
    assign zero_start = state_q == IDLE && start && count_q == 32'd0;
    // a completion event in the same cycle as a STATUS read keeps the flag set
    assign done_d     = finish || zero_start || (done_q && !rd_status);
    assign aborted_d  = (finish && aborting) || (aborted_q && !rd_status);

    fb_fill_addr_gen u_addr_gen (
        .clk      (clk),
        .resetn   (resetn),
        .load_i   (load),
        .advance_i(accept),
        .base_i   (base_q),
        .count_i  (count_q),
        .ptr_o    (ptr),
        .last_o   (last)
    );

`ifdef FB_FILL_IRQ_EN
    logic irq_en_q;
    logic irq_q;

    // programmed registers; writes while busy never reach the working copies
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            base_q   <= '0;
            count_q  <= '0;
            colour_q <= '0;
            irq_en_q <= 1'b0;
        end else if (bus.slave_write_en) begin
            if (bus.slave_address == REG_BASE)   base_q   <= {bus.slave_write_data[31:2], 2'b00};
            if (bus.slave_address == REG_COUNT)  count_q  <= bus.slave_write_data;
            if (bus.slave_address == REG_COLOUR) colour_q <= bus.slave_write_data;
            if (bus.slave_address == REG_CTRL)   irq_en_q <= bus.slave_write_data[CTRL_IRQ_EN];
        end
    end

    // irq follows the next-state flags so it rises together with done
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) irq_q <= 1'b0;
        else         irq_q <= irq_en_q && (done_d || aborted_d);
    end

    assign irq = irq_q;
`else
    // programmed registers; writes while busy never reach the working copies
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            base_q   <= '0;
            count_q  <= '0;
            colour_q <= '0;
        end else if (bus.slave_write_en) begin
            if (bus.slave_address == REG_BASE)   base_q   <= {bus.slave_write_data[31:2], 2'b00};
            if (bus.slave_address == REG_COUNT)  count_q  <= bus.slave_write_data;
            if (bus.slave_address == REG_COLOUR) colour_q <= bus.slave_write_data;
        end
    end
`endif

    // fill FSM with registered master_write, latched colour, pending abort and sticky flags
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            master_write_q <= 1'b0;
            colour_w_q     <= '0;
            abort_pend_q   <= 1'b0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                if (load) begin
                    state_q        <= RUN;
                    master_write_q <= 1'b1;
                    colour_w_q     <= colour_q;
                    abort_pend_q   <= 1'b0;
                end
            end else if (finish) begin
                state_q        <= IDLE;
                master_write_q <= 1'b0;
                abort_pend_q   <= 1'b0;
            end else if (abort_wr) begin
                abort_pend_q <= 1'b1;
            end
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    // zero-latency register read mux
    always_comb begin
        rdata = '0;
        if (bus.slave_read_en)
            rdata = bus.slave_address == REG_CTRL  ? {29'd0, aborted_q, done_q, state_q == RUN} :
                    bus.slave_address == REG_BASE  ? base_q :
                    bus.slave_address == REG_COUNT ? count_q : colour_q;
    end

    assign bus.slave_read_data   = rdata;
    assign bus.master_address    = ptr;
    assign bus.master_write      = master_write_q;
    assign bus.master_write_data = colour_w_q;

endmodule

// File: tb/tb_fb_fill_engine.sv
// tb_fb_fill_engine: directed self-checking bench for fb_fill_engine
module tb_fb_fill_engine;

    logic clk;
    logic resetn;
    int   errors;
    int   checks;
    logic [31:0] beat_addr[$];
    logic [31:0] beat_data[$];

    fb_fill_if bus();

`ifdef FB_FILL_IRQ_EN
    logic irq;
    fb_fill_engine dut (.clk(clk), .resetn(resetn), .bus(bus), .irq(irq));
`else
    fb_fill_engine dut (.clk(clk), .resetn(resetn), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // record every accepted beat
    always @(posedge clk)
        if (resetn && bus.master_write && !bus.master_wait_request) begin
            beat_addr.push_back(bus.master_address);
            beat_data.push_back(bus.master_write_data);
        end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.slave_address    = a;
        bus.slave_write_data = d;
        bus.slave_write_en   = 1'b1;
        step();
        bus.slave_write_en   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.slave_address = a;
        bus.slave_read_en = 1'b1;
        #1;
        d = bus.slave_read_data;
        step();
        bus.slave_read_en = 1'b0;
    endtask

    task automatic clear_beats();
        beat_addr.delete();
        beat_data.delete();
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (bus.master_write === 1'b1 && n < max) begin
            step();
            n++;
        end
        checks++;
        if (bus.master_write !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: master_write=%b after %0d cycles, required 0", bus.master_write, n);
        end
    endtask

    task automatic check_beats(input string name, input int n, input logic [31:0] base, input logic [31:0] colour);
        checks++;
        if (beat_addr.size() != n) begin
            errors++;
            $display("FAIL %s beat count: got %0d, required %0d", name, beat_addr.size(), n);
        end else
            for (int i = 0; i < n; i++) begin
                checks++;
                if (beat_addr[i] !== base + 32'(4 * i) || beat_data[i] !== colour) begin
                    errors++;
                    $display("FAIL %s beat %0d: addr=%h data=%h, required addr=%h data=%h",
                             name, i, beat_addr[i], beat_data[i], base + 32'(4 * i), colour);
                end
            end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #1;
        checks++;
        if (bus.master_write !== 1'b0 || bus.master_address !== 32'd0 || bus.master_write_data !== 32'd0 ||
            bus.slave_read_data !== 32'd0) begin
            errors++;
            $display("FAIL reset outputs: mw=%b addr=%h data=%h rdata=%h, required all 0",
                     bus.master_write, bus.master_address, bus.master_write_data, bus.slave_read_data);
        end
        resetn = 1'b1;
        step();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("FAIL reset reg %0d: got %h, required 0", a, d);
            end
        end
    endtask

    task automatic test_fill_basic();
        logic [31:0] d;
        wr(2'd1, 32'h0010_0000);
        wr(2'd2, 32'd4);
        wr(2'd3, 32'h00FF_00FF);
        rd(2'd1, d);
        checks++;
        if (d !== 32'h0010_0000) begin
            errors++;
            $display("FAIL basic base readback: got %h, required 00100000", d);
        end
        clear_beats();
        wr(2'd0, 32'h1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.master_write !== 1'b1 || bus.master_address !== 32'h0010_0000 + 32'(4 * k) ||
                bus.master_write_data !== 32'h00FF_00FF) begin
                errors++;
                $display("FAIL basic cycle %0d: mw=%b addr=%h data=%h, required mw=1 addr=%h data=00ff00ff",
                         k, bus.master_write, bus.master_address, bus.master_write_data, 32'h0010_0000 + 32'(4 * k));
            end
            step();
        end
        checks++;
        if (bus.master_write !== 1'b0) begin
            errors++;
            $display("FAIL basic end: mw=%b, required 0", bus.master_write);
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL basic status: got %h, required 2", d);
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL basic status reread: got %h, required 0", d);
        end
        check_beats("basic", 4, 32'h0010_0000, 32'h00FF_00FF);
    endtask

    task automatic test_stall();
        logic [31:0] d;
        clear_beats();
        wr(2'd0, 32'h1);
        step();
        bus.master_wait_request = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.master_write !== 1'b1 || bus.master_address !== 32'h0010_0004 ||
                bus.master_write_data !== 32'h00FF_00FF) begin
                errors++;
                $display("FAIL stall hold %0d: mw=%b addr=%h data=%h, required mw=1 addr=00100004 data=00ff00ff",
                         k, bus.master_write, bus.master_address, bus.master_write_data);
            end
            step();
        end
        bus.master_wait_request = 1'b0;
        wait_idle(20);
        rd(2'd0, d);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL stall status: got %h, required 2", d);
        end
        check_beats("stall", 4, 32'h0010_0000, 32'h00FF_00FF);
    endtask

    task automatic test_zero_count();
        logic [31:0] d;
        wr(2'd2, 32'd0);
        clear_beats();
        wr(2'd0, 32'h1);
        checks++;
        if (bus.master_write !== 1'b0) begin
            errors++;
            $display("FAIL zero mw: got %b, required 0", bus.master_write);
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL zero status: got %h, required 2", d);
        end
        check_beats("zero", 0, 32'h0, 32'h0);
        wr(2'd0, 32'h2);
        rd(2'd0, d);
        checks++;
        if (d !== 32'h0 || bus.master_write !== 1'b0) begin
            errors++;
            $display("FAIL idle abort: status=%h mw=%b, required 0 and 0", d, bus.master_write);
        end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        wr(2'd1, 32'h0020_0000);
        wr(2'd2, 32'd1000);
        wr(2'd3, 32'hA5A5_5A5A);
        clear_beats();
        wr(2'd0, 32'h1);
        for (int k = 0; k < 10; k++) step();
        bus.master_wait_request = 1'b1;
        wr(2'd0, 32'h2);
        wr(2'd2, 32'd7);
        bus.master_wait_request = 1'b0;
        step();
        checks++;
        if (bus.master_write !== 1'b0) begin
            errors++;
            $display("FAIL abort end: mw=%b, required 0", bus.master_write);
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'h6) begin
            errors++;
            $display("FAIL abort status: got %h, required 6", d);
        end
        check_beats("abort", 11, 32'h0020_0000, 32'hA5A5_5A5A);
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        wr(2'd1, 32'hFFFF_FFFB);
        wr(2'd2, 32'd3);
        wr(2'd3, 32'h1234_5678);
        rd(2'd1, d);
        checks++;
        if (d !== 32'hFFFF_FFF8) begin
            errors++;
            $display("FAIL wrap base align: got %h, required fffffff8", d);
        end
        clear_beats();
        wr(2'd0, 32'h3);
        wait_idle(20);
        check_beats("wrap", 3, 32'hFFFF_FFF8, 32'h1234_5678);
        rd(2'd0, d);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL wrap status: got %h, required 2", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wr(2'd1, 32'h0030_0000);
        wr(2'd2, 32'd100);
        wr(2'd0, 32'h1);
        step();
        step();
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.master_write !== 1'b0) begin
            errors++;
            $display("FAIL reset mid mw: got %b, required 0", bus.master_write);
        end
        step();
        step();
        resetn = 1'b1;
        step();
        checks++;
        if (bus.master_write !== 1'b0 || bus.master_address !== 32'd0 || bus.master_write_data !== 32'd0) begin
            errors++;
            $display("FAIL reset mid outputs: mw=%b addr=%h data=%h, required all 0",
                     bus.master_write, bus.master_address, bus.master_write_data);
        end
`ifdef FB_FILL_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset mid irq: got %b, required 0", irq);
        end
`endif
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("FAIL reset mid reg %0d: got %h, required 0", a, d);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        resetn = 1'b0;
        bus.slave_address       = 2'd0;
        bus.slave_read_en       = 1'b0;
        bus.slave_write_en      = 1'b0;
        bus.slave_write_data    = 32'd0;
        bus.master_wait_request = 1'b0;
        step();
        step();
        test_reset();
        test_fill_basic();
        test_stall();
        test_zero_count();
        test_abort();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
